// File: rtl/median_window_feeder.sv
// rtl/median_window_feeder.sv - header/pixel feeder for median windows (optional MEDIAN_FEEDER_WINDOW_CNT_EN)
module median_window_feeder #(
    parameter int WINDOW_SIZE    = 1024,
    parameter int MEDIAN_POS     = 512,
    parameter int BUFF_SIZE_BIT  = 16,
    parameter int DEFAULT_PIVOT  = 127,
    parameter int DEFAULT_SECOND = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               in_px,
    input  logic                     in_px_empty,
    output logic                     in_px_rd,
    output logic [7:0]               out_px,
    output logic                     out_px_wr,
    input  logic                     out_px_full,
    output logic [7:0]               out_pivot,
    output logic                     out_pivot_wr,
    input  logic                     out_pivot_full,
    output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
    output logic                     out_buff_size_wr,
    input  logic                     out_buff_size_full,
    output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
    output logic                     out_median_pos_wr,
    input  logic                     out_median_pos_full,
    output logic [7:0]               out_second_median_value,
    output logic                     out_second_median_value_wr,
    input  logic                     out_second_median_value_full,
`ifdef MEDIAN_FEEDER_WINDOW_CNT_EN
    output logic [15:0]              window_cnt,
    output logic                     window_done,
`endif
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HDR    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [BUFF_SIZE_BIT-1:0] LAST_IDX = BUFF_SIZE_BIT'(WINDOW_SIZE - 1);

    logic [1:0]               state;
    logic [BUFF_SIZE_BIT-1:0] px_count;
    logic                     hdr_wr;
    logic                     px_xfer;
    logic                     last_px;
    logic                     load_hdr;

    // Handshake decode: header goes out only as one atomic 4-token write, pixels pass straight through
    always_comb begin
        hdr_wr   = (state == ST_HDR) && !out_pivot_full && !out_buff_size_full
                   && !out_median_pos_full && !out_second_median_value_full;
        px_xfer  = (state == ST_STREAM) && !in_px_empty && !out_px_full;
        last_px  = px_xfer && (px_count == LAST_IDX);
        load_hdr = enable && ((state == ST_IDLE) || last_px);
    end

    assign in_px_rd                   = px_xfer;
    assign out_px_wr                  = px_xfer;
    assign out_px                     = in_px;
    assign out_pivot_wr               = hdr_wr;
    assign out_buff_size_wr           = hdr_wr;
    assign out_median_pos_wr          = hdr_wr;
    assign out_second_median_value_wr = hdr_wr;
    assign busy                       = (state != ST_IDLE);

    // Window sequencing: a window always runs to WINDOW_SIZE pixels once its header is out
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            px_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_HDR;
                        px_count <= '0;
                    end
                end
                ST_HDR: begin
                    if (hdr_wr) state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (last_px) begin
                        state    <= enable ? ST_HDR : ST_IDLE;
                        px_count <= '0;
                    end else if (px_xfer) begin
                        px_count <= px_count + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    px_count <= '0;
                end
            endcase
        end
    end

    // Header token registers, reloaded with the per-window defaults whenever a header is entered
    always_ff @(posedge clock) begin
        if (reset) begin
            out_pivot               <= '0;
            out_buff_size           <= '0;
            out_median_pos          <= '0;
            out_second_median_value <= '0;
        end else if (load_hdr) begin
            out_pivot               <= 8'(DEFAULT_PIVOT);
            out_buff_size           <= BUFF_SIZE_BIT'(WINDOW_SIZE);
            out_median_pos          <= BUFF_SIZE_BIT'(MEDIAN_POS);
            out_second_median_value <= 8'(DEFAULT_SECOND);
        end
    end

`ifdef MEDIAN_FEEDER_WINDOW_CNT_EN
    // Completed-window counter (wraps naturally) and a registered pulse one cycle after each final pixel
    always_ff @(posedge clock) begin
        if (reset) begin
            window_cnt  <= '0;
            window_done <= 1'b0;
        end else begin
            window_done <= last_px;
            if (last_px) window_cnt <= window_cnt + 16'd1;
        end
    end
`endif

endmodule
